// File: rtl/alu_seq.sv
// -----------------------------------------------------------------------------
// alu_seq -- multi-cycle ALU with a valid/ready front end.
//
// Takes one operation at a time over an in_valid/in_ready handshake. Most
// operations finish in a single cycle. Shifts and rotates run one bit position
// per EXEC cycle. MUL, when built in, runs one shift-add step per EXEC cycle.
// The result, flags and branch decision are registered. They are held on the
// outputs while out_valid is high and until out_ready takes them.
//
// Optional feature: define ALU_SEQ_MUL_EN to build the unsigned shift-add
// multiplier (opcode 10101). When the macro is not defined, 10101 is decoded
// as an illegal opcode and no multiplier logic exists.
//
// Ports:
//   clk        in   rising-edge clock
//   reset_n    in   asynchronous active-low reset; aborts any operation
//   in_valid   in   operation presented
//   in_ready   out  high only in IDLE; operation accepted when both are high
//   alu_cmd    in   opcode (CMD_W bits), latched on accept
//   inA, inB   in   operands (WIDTH bits), latched on accept
//   out_valid  out  result valid; held until out_ready
//   out_ready  in   consumer takes the result
//   rslt       out  result (low half of the product for MUL)
//   rslt_hi    out  high half of the product for MUL, else 0
//   doBranch   out  branch taken (BEQ / B only)
//   flag_z     out  zero flag (full product for MUL)
//   flag_c     out  carry / borrow / last bit shifted out
//   flag_n     out  MSB of rslt
//   illegal    out  opcode not recognised
// -----------------------------------------------------------------------------
module alu_seq #(
    parameter int WIDTH = 8,
    parameter int CMD_W = 5,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [CMD_W-1:0] alu_cmd,
    input  logic [WIDTH-1:0] inA,
    input  logic [WIDTH-1:0] inB,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] rslt,
    output logic [WIDTH-1:0] rslt_hi,
    output logic             doBranch,
    output logic             flag_z,
    output logic             flag_c,
    output logic             flag_n,
    output logic             illegal
);

    // Opcodes
    localparam logic [CMD_W-1:0] OP_NOP    = CMD_W'(5'b00000);
    localparam logic [CMD_W-1:0] OP_B      = CMD_W'(5'b00010);
    localparam logic [CMD_W-1:0] OP_BEQ    = CMD_W'(5'b00011);
    localparam logic [CMD_W-1:0] OP_MOV    = CMD_W'(5'b00100);
    localparam logic [CMD_W-1:0] OP_SLT    = CMD_W'(5'b00101);
    localparam logic [CMD_W-1:0] OP_ADD    = CMD_W'(5'b01000);
    localparam logic [CMD_W-1:0] OP_SUB    = CMD_W'(5'b01001);
    localparam logic [CMD_W-1:0] OP_AND    = CMD_W'(5'b01010);
    localparam logic [CMD_W-1:0] OP_OR     = CMD_W'(5'b01011);
    localparam logic [CMD_W-1:0] OP_SHL    = CMD_W'(5'b01100);
    localparam logic [CMD_W-1:0] OP_SHR    = CMD_W'(5'b01101);
    localparam logic [CMD_W-1:0] OP_PARITY = CMD_W'(5'b01111);
    localparam logic [CMD_W-1:0] OP_XOR    = CMD_W'(5'b10100);
    localparam logic [CMD_W-1:0] OP_ADDI   = CMD_W'(5'b11000);
    localparam logic [CMD_W-1:0] OP_ROTL   = CMD_W'(5'b11110);
`ifdef ALU_SEQ_MUL_EN
    localparam logic [CMD_W-1:0] OP_MUL    = CMD_W'(5'b10101);
    localparam logic [SHW-1:0]   CNT_MUL   = SHW'(WIDTH - 1);
`endif

    localparam logic [WIDTH-1:0] W_L     = WIDTH'(WIDTH);
    localparam logic [WIDTH-1:0] ONE_W   = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH:0]   ONE_W1  = {{WIDTH{1'b0}}, 1'b1};
    localparam logic [SHW-1:0]   CNT_ONE = SHW'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    // Even-parity bit of a data word
    function automatic logic parity_f(input logic [WIDTH-1:0] v);
        return ^v;
    endfunction

    state_t             state_r;
    logic               in_ready_r;
    logic               out_valid_r;
    logic [CMD_W-1:0]   cmd_r;
    logic [WIDTH-1:0]   acc_r;
    logic [SHW-1:0]     cnt_r;
    logic [WIDTH-1:0]   rslt_r;
    logic [WIDTH-1:0]   rslt_hi_r;
    logic               branch_r;
    logic               flag_z_r;
    logic               flag_c_r;
    logic               flag_n_r;
    logic               illegal_r;
`ifdef ALU_SEQ_MUL_EN
    logic [WIDTH-1:0]   mcand_r;
    logic [WIDTH-1:0]   hi_r;
    logic [WIDTH:0]     mul_sum_s;
`endif

    // Decode of the presented operation: single-cycle result or iteration setup
    logic [WIDTH-1:0]   sc_rslt_s;
    logic               sc_c_s;
    logic               sc_br_s;
    logic               sc_ill_s;
    logic               iter_s;
    logic [SHW-1:0]     cnt_load_s;
    logic [SHW-1:0]     rot_n_s;

    // Step values for one EXEC cycle
    logic [WIDTH-1:0]   step_acc_s;
    logic [WIDTH-1:0]   step_hi_s;
    logic               step_c_s;

    // Decode the opcode at the inputs into a single-cycle result or an iteration count
    always_comb begin
        sc_rslt_s  = '0;
        sc_c_s     = 1'b0;
        sc_br_s    = 1'b0;
        sc_ill_s   = 1'b0;
        iter_s     = 1'b0;
        cnt_load_s = '0;
        rot_n_s    = SHW'(inB % W_L);
        case (alu_cmd)
            OP_NOP:    sc_rslt_s = '0;
            OP_ADD:    {sc_c_s, sc_rslt_s} = {1'b0, inA} + {1'b0, inB};
            OP_ADDI:   {sc_c_s, sc_rslt_s} = {1'b0, inA} + {1'b0, inB} + ONE_W1;
            // top bit of the widened difference is the borrow
            OP_SUB:    {sc_c_s, sc_rslt_s} = {1'b0, inA} - {1'b0, inB};
            OP_MOV:    sc_rslt_s = inB;
            OP_AND:    sc_rslt_s = inA & inB;
            OP_OR:     sc_rslt_s = inA | inB;
            OP_XOR:    sc_rslt_s = inA ^ inB;
            OP_PARITY: sc_rslt_s = {{(WIDTH-1){1'b0}}, parity_f(inA)};
            OP_SLT: begin
                if (inA < inB) begin
                    sc_rslt_s = ONE_W;
                end else begin
                    sc_rslt_s = '0;
                end
            end
            OP_BEQ:    sc_br_s = (inA == inB);
            OP_B:      sc_br_s = 1'b1;
            OP_SHL, OP_SHR: begin
                // Shifting by WIDTH or more clears everything: no iteration needed
                if (inB >= W_L) begin
                    sc_rslt_s = '0;
                end else if (inB == '0) begin
                    sc_rslt_s = inA;
                end else begin
                    iter_s     = 1'b1;
                    cnt_load_s = SHW'(inB) - CNT_ONE;
                end
            end
            OP_ROTL: begin
                if (rot_n_s == '0) begin
                    sc_rslt_s = inA;
                end else begin
                    iter_s     = 1'b1;
                    cnt_load_s = rot_n_s - CNT_ONE;
                end
            end
`ifdef ALU_SEQ_MUL_EN
            OP_MUL: begin
                iter_s     = 1'b1;
                cnt_load_s = CNT_MUL;
            end
`endif
            default:   sc_ill_s = 1'b1;
        endcase
    end

    // One bit of shift / rotate / shift-add work on the latched operands
    always_comb begin
        step_acc_s = acc_r;
        step_hi_s  = '0;
        step_c_s   = 1'b0;
`ifdef ALU_SEQ_MUL_EN
        mul_sum_s  = '0;
`endif
        case (cmd_r)
            OP_SHL: begin
                step_acc_s = {acc_r[WIDTH-2:0], 1'b0};
                step_c_s   = acc_r[WIDTH-1];
            end
            OP_SHR: begin
                step_acc_s = {1'b0, acc_r[WIDTH-1:1]};
                step_c_s   = acc_r[0];
            end
            OP_ROTL: begin
                step_acc_s = {acc_r[WIDTH-2:0], acc_r[WIDTH-1]};
                step_c_s   = 1'b0;
            end
`ifdef ALU_SEQ_MUL_EN
            OP_MUL: begin
                // {hi, acc} holds the partial product above the unconsumed multiplier bits
                if (acc_r[0]) begin
                    mul_sum_s = {1'b0, hi_r} + {1'b0, mcand_r};
                end else begin
                    mul_sum_s = {1'b0, hi_r};
                end
                step_hi_s  = mul_sum_s[WIDTH:1];
                step_acc_s = {mul_sum_s[0], acc_r[WIDTH-1:1]};
                step_c_s   = (mul_sum_s[WIDTH:1] != '0);
            end
`endif
            default: begin
                step_acc_s = acc_r;
                step_c_s   = 1'b0;
            end
        endcase
    end

    // Control FSM with the operand latches, iteration counter and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= ST_IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            cmd_r       <= '0;
            acc_r       <= '0;
            cnt_r       <= '0;
            rslt_r      <= '0;
            rslt_hi_r   <= '0;
            branch_r    <= 1'b0;
            flag_z_r    <= 1'b0;
            flag_c_r    <= 1'b0;
            flag_n_r    <= 1'b0;
            illegal_r   <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
            mcand_r     <= '0;
            hi_r        <= '0;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid) begin
                        cmd_r      <= alu_cmd;
                        acc_r      <= inA;
                        cnt_r      <= cnt_load_s;
                        in_ready_r <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
                        mcand_r    <= inB;
                        hi_r       <= '0;
`endif
                        if (iter_s) begin
                            state_r <= ST_EXEC;
                        end else begin
                            state_r     <= ST_DONE;
                            out_valid_r <= 1'b1;
                            rslt_r      <= sc_rslt_s;
                            rslt_hi_r   <= '0;
                            branch_r    <= sc_br_s;
                            flag_z_r    <= (sc_rslt_s == '0);
                            flag_c_r    <= sc_c_s;
                            flag_n_r    <= sc_rslt_s[WIDTH-1];
                            illegal_r   <= sc_ill_s;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_EXEC: begin
                    acc_r <= step_acc_s;
`ifdef ALU_SEQ_MUL_EN
                    hi_r  <= step_hi_s;
`endif
                    if (cnt_r == '0) begin
                        state_r     <= ST_DONE;
                        out_valid_r <= 1'b1;
                        rslt_r      <= step_acc_s;
                        rslt_hi_r   <= step_hi_s;
                        branch_r    <= 1'b0;
                        flag_z_r    <= ({step_hi_s, step_acc_s} == '0);
                        flag_c_r    <= step_c_s;
                        flag_n_r    <= step_acc_s[WIDTH-1];
                        illegal_r   <= 1'b0;
                    end else begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_r     <= ST_IDLE;
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                    end else begin
                        state_r <= ST_DONE;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign rslt      = rslt_r;
    assign rslt_hi   = rslt_hi_r;
    assign doBranch  = branch_r;
    assign flag_z    = flag_z_r;
    assign flag_c    = flag_c_r;
    assign flag_n    = flag_n_r;
    assign illegal   = illegal_r;

endmodule

// File: tb/tb_alu_seq.sv
// -----------------------------------------------------------------------------
// tb_alu_seq -- directed self-checking bench for alu_seq (WIDTH = 8).
// Expected values are hand-computed constants. Result outputs are packed as
// {rslt_hi, rslt, doBranch, flag_z, flag_c, flag_n, illegal}.
// -----------------------------------------------------------------------------
module tb_alu_seq;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       in_valid;
    logic       in_ready;
    logic [4:0] alu_cmd;
    logic [7:0] inA;
    logic [7:0] inB;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] rslt;
    logic [7:0] rslt_hi;
    logic       doBranch;
    logic       flag_z;
    logic       flag_c;
    logic       flag_n;
    logic       illegal;

    int n_vec = 0;
    int n_err = 0;
    int lat;

    alu_seq #(.WIDTH(8), .CMD_W(5)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_cmd   (alu_cmd),
        .inA       (inA),
        .inB       (inB),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .rslt      (rslt),
        .rslt_hi   (rslt_hi),
        .doBranch  (doBranch),
        .flag_z    (flag_z),
        .flag_c    (flag_c),
        .flag_n    (flag_n),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] outs();
        return 32'({rslt_hi, rslt, doBranch, flag_z, flag_c, flag_n, illegal});
    endfunction

    function automatic logic [31:0] pk(input logic [7:0] hi, input logic [7:0] r,
                                       input logic br, input logic z, input logic c,
                                       input logic n, input logic ill);
        return 32'({hi, r, br, z, c, n, ill});
    endfunction

    // Present an operation, wait (bounded) for out_valid; lat = cycles after accept
    task automatic run_op(input string tag, input logic [4:0] cmd,
                          input logic [7:0] a, input logic [7:0] b, output int l);
        chk({tag, "/in_ready"}, 32'(in_ready), 32'd1);
        alu_cmd  = cmd;
        inA      = a;
        inB      = b;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        l = 1;
        while (!out_valid && l < 40) begin
            @(posedge clk); #1;
            l++;
        end
        chk({tag, "/out_valid"}, 32'(out_valid), 32'd1);
    endtask

    task automatic take_result();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        alu_cmd   = 5'b00000;
        inA       = 8'h00;
        inB       = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        chk("rst/out_valid", 32'(out_valid), 32'd0);
        chk("rst/in_ready", 32'(in_ready), 32'd1);
        chk("rst/outs", outs(), pk(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        reset_n = 1'b1;
        @(posedge clk); #1;

        // ADD with carry out, single-cycle latency
        run_op("add_f0_20", 5'b01000, 8'hF0, 8'h20, lat);
        chk("add_f0_20/lat", 32'(lat), 32'd1);
        chk("add_f0_20/outs", outs(), pk(8'h00, 8'h10, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
        take_result();

        // Reset in the middle of SHL B=5 after two EXEC cycles
        alu_cmd  = 5'b01100;
        inA      = 8'h81;
        inB      = 8'h05;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("shl_abort/busy", 32'(in_ready), 32'd0);
        reset_n = 1'b0;
        #1;
        chk("shl_abort/out_valid", 32'(out_valid), 32'd0);
        chk("shl_abort/in_ready", 32'(in_ready), 32'd1);
        chk("shl_abort/outs", outs(), pk(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        chk("shl_abort/no_result", 32'(out_valid), 32'd0);

        run_op("add_3_4", 5'b01000, 8'h03, 8'h04, lat);
        chk("add_3_4/lat", 32'(lat), 32'd1);
        chk("add_3_4/outs", outs(), pk(8'h00, 8'h07, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        take_result();

        run_op("sub_5_5", 5'b01001, 8'h05, 8'h05, lat);
        chk("sub_5_5/outs", outs(), pk(8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
        take_result();

        run_op("sub_3_5", 5'b01001, 8'h03, 8'h05, lat);
        chk("sub_3_5/outs", outs(), pk(8'h00, 8'hFE, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0));
        take_result();

        run_op("addi_ff_00", 5'b11000, 8'hFF, 8'h00, lat);
        chk("addi_ff_00/outs", outs(), pk(8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
        take_result();

        run_op("slt_3_5", 5'b00101, 8'h03, 8'h05, lat);
        chk("slt_3_5/outs", outs(), pk(8'h00, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        take_result();

        run_op("parity_07", 5'b01111, 8'h07, 8'h00, lat);
        chk("parity_07/outs", outs(), pk(8'h00, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        take_result();

        // ROTL by 9 is a rotate by 1: one EXEC cycle
        run_op("rotl_81_9", 5'b11110, 8'h81, 8'h09, lat);
        chk("rotl_81_9/lat", 32'(lat), 32'd2);
        chk("rotl_81_9/outs", outs(), pk(8'h00, 8'h03, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        take_result();

        run_op("shr_81_0", 5'b01101, 8'h81, 8'h00, lat);
        chk("shr_81_0/lat", 32'(lat), 32'd1);
        chk("shr_81_0/outs", outs(), pk(8'h00, 8'h81, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
        take_result();

        run_op("shl_ff_8", 5'b01100, 8'hFF, 8'h08, lat);
        chk("shl_ff_8/rslt", 32'(rslt), 32'h00);
        chk("shl_ff_8/z", 32'(flag_z), 32'd1);
        take_result();

        run_op("shl_81_1", 5'b01100, 8'h81, 8'h01, lat);
        chk("shl_81_1/lat", 32'(lat), 32'd2);
        chk("shl_81_1/outs", outs(), pk(8'h00, 8'h02, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
        take_result();

        // 0xB6 >> 3: bits out are 0,1,1 -> last out is 1
        run_op("shr_b6_3", 5'b01101, 8'hB6, 8'h03, lat);
        chk("shr_b6_3/lat", 32'(lat), 32'd4);
        chk("shr_b6_3/outs", outs(), pk(8'h00, 8'h16, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
        take_result();

        // Backpressure: BEQ held for 4 cycles while another op is offered
        run_op("beq_3c", 5'b00011, 8'h3C, 8'h3C, lat);
        alu_cmd  = 5'b01000;
        inA      = 8'h01;
        inB      = 8'h01;
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("beq_3c/hold_valid", 32'(out_valid), 32'd1);
            chk("beq_3c/hold_in_ready", 32'(in_ready), 32'd0);
            chk("beq_3c/hold_outs", outs(), pk(8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        take_result();
        chk("beq_3c/released", 32'(in_ready), 32'd1);
        chk("beq_3c/no_extra", 32'(out_valid), 32'd0);

        run_op("beq_ne", 5'b00011, 8'h3C, 8'h3D, lat);
        chk("beq_ne/outs", outs(), pk(8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
        take_result();

        run_op("illegal_1a", 5'b11010, 8'h12, 8'h34, lat);
        chk("illegal_1a/lat", 32'(lat), 32'd1);
        chk("illegal_1a/outs", outs(), pk(8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1));
        take_result();

        run_op("xor_aa_0f", 5'b10100, 8'hAA, 8'h0F, lat);
        chk("xor_aa_0f/outs", outs(), pk(8'h00, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
        take_result();

`ifdef ALU_SEQ_MUL_EN
        run_op("mul_ff_ff", 5'b10101, 8'hFF, 8'hFF, lat);
        chk("mul_ff_ff/lat", 32'(lat), 32'd9);
        chk("mul_ff_ff/outs", outs(), pk(8'hFE, 8'h01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
        take_result();

        run_op("mul_0c_0b", 5'b10101, 8'h0C, 8'h0B, lat);
        chk("mul_0c_0b/outs", outs(), pk(8'h00, 8'h84, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
        take_result();
`else
        run_op("mul_off", 5'b10101, 8'hFF, 8'hFF, lat);
        chk("mul_off/lat", 32'(lat), 32'd1);
        chk("mul_off/outs", outs(), pk(8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1));
        take_result();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
